// File: rtl/feedback_pkg.sv
// Shared constants and helpers for feedback-loop blocks: saturation limits,
// a wide signed clamp and integrator width checks.
package feedback_pkg;

  localparam int CLAMP_W = 64;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // (2^(w-1)-1) << sh, i.e. the positive integrator limit for a w-bit DAC
  function automatic logic signed [CLAMP_W-1:0] sat_max(input int w, input int sh);
    logic signed [CLAMP_W-1:0] one;
    one = 64'sd1;
    return ((one <<< (w - 1)) - 64'sd1) <<< sh;
  endfunction

  function automatic logic signed [CLAMP_W-1:0] sclamp(
    input logic signed [CLAMP_W-1:0] x,
    input logic signed [CLAMP_W-1:0] lo,
    input logic signed [CLAMP_W-1:0] hi
  );
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic bit acc_width_ok(input int acc_w, input int dac_w, input int sh);
    return acc_w >= dac_w + sh + 1;
  endfunction

endpackage

// File: rtl/pi_feedback_controller_sat_shift.sv
// Arithmetic right shift followed by signed saturation to OUT_W bits,
// with a flag raised whenever the value had to be clipped.
module sat_shift #(
  parameter int IN_W  = 49,
  parameter int OUT_W = 17,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic signed [OUT_W-1:0] y_o,
  output logic                    clip_o
);

  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = ~MAXV;

  logic signed [IN_W-1:0] y;

  always_comb begin
    y      = x_i >>> SHIFT;
    y_o    = OUT_W'(y);
    clip_o = 1'b0;
    if (y > MAXV) begin
      y_o    = OUT_W'(MAXV);
      clip_o = 1'b1;
    end else if (y < MINV) begin
      y_o    = OUT_W'(MINV);
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/pi_feedback_controller.sv
// Four-stage PI controller in the ADC->DAC loop: error, gain products,
// anti-windup integrator, then shift/saturate to the DAC word.
module pi_feedback_controller
  import feedback_pkg::*;
#(
  parameter int ADC_WIDTH  = 19,
  parameter int DAC_WIDTH  = 17,
  parameter int GAIN_WIDTH = 16,
  parameter int OUT_SHIFT  = 0,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         adc_valid,
  input  logic signed [ADC_WIDTH-1:0]  adc_data,
  input  logic signed [ADC_WIDTH-1:0]  setpoint,
  input  logic signed [GAIN_WIDTH-1:0] kp,
  input  logic signed [GAIN_WIDTH-1:0] ki,
  input  logic                         integrate,
  input  logic                         hold_mode,
  output logic signed [DAC_WIDTH-1:0]  dac_data,
  output logic                         dac_valid,
  output logic                         sat_flag
);

  localparam int ERR_W = ADC_WIDTH + 1;
  localparam int PRD_W = ADC_WIDTH + GAIN_WIDTH + 1;
  localparam int SUM_W = max_i(ACC_WIDTH, PRD_W) + 1;
  localparam logic signed [CLAMP_W-1:0] IMAX = sat_max(DAC_WIDTH, OUT_SHIFT);
  localparam logic signed [CLAMP_W-1:0] IMIN = -IMAX - 64'sd1;

  logic [3:1]                  vld_q;
  logic signed [ERR_W-1:0]     err_q,  err_d;
  logic signed [PRD_W-1:0]     p2_q,   p2_d;
  logic signed [PRD_W-1:0]     i2_q,   i2_d;
  logic signed [PRD_W-1:0]     p3_q;
  logic signed [ACC_WIDTH-1:0] acc_q,  acc_d;
  logic signed [DAC_WIDTH-1:0] dac_q;
  logic                        dac_vld_q, sat_q;

  logic signed [SUM_W-1:0]     sum;
  logic signed [DAC_WIDTH-1:0] y_sat;
  logic                        y_clip, acc_at_lim;

  always_comb begin
    err_d = ERR_W'(adc_data) - ERR_W'(setpoint);
    p2_d  = PRD_W'(kp) * PRD_W'(err_q);
    i2_d  = PRD_W'(ki) * PRD_W'(err_q);

    // Mode inputs are levels seen at S3; a clear wins even with no sample in flight.
    acc_d = acc_q;
    if (vld_q[2] && integrate)
      acc_d = ACC_WIDTH'(sclamp(CLAMP_W'(acc_q) + CLAMP_W'(i2_q), IMIN, IMAX));
    else if (!integrate && !hold_mode)
      acc_d = '0;
  end

  assign sum        = SUM_W'(p3_q) + SUM_W'(acc_q);
  assign acc_at_lim = (CLAMP_W'(acc_q) == IMAX) || (CLAMP_W'(acc_q) == IMIN);

  sat_shift #(
    .IN_W  (SUM_W),
    .OUT_W (DAC_WIDTH),
    .SHIFT (OUT_SHIFT)
  ) u_sat (
    .x_i    (sum),
    .y_o    (y_sat),
    .clip_o (y_clip)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q     <= '0;
      err_q     <= '0;
      p2_q      <= '0;
      i2_q      <= '0;
      p3_q      <= '0;
      acc_q     <= '0;
      dac_q     <= '0;
      dac_vld_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      vld_q     <= {vld_q[2:1], adc_valid};
      err_q     <= err_d;
      p2_q      <= p2_d;
      i2_q      <= i2_d;
      p3_q      <= p2_q;
      acc_q     <= acc_d;
      dac_vld_q <= vld_q[3];
      if (vld_q[3]) begin
        dac_q <= y_sat;
        sat_q <= y_clip | acc_at_lim;
      end
    end
  end

  assign dac_data  = dac_q;
  assign dac_valid = dac_vld_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_pi_feedback_controller.sv
// Directed bench for pi_feedback_controller with hand-computed expectations.
module tb_pi_feedback_controller;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               adc_valid = 1'b0;
  logic signed [18:0] adc_data = '0;
  logic signed [18:0] setpoint = 19'sd1000;
  logic signed [15:0] kp = 16'sd0;
  logic signed [15:0] ki = 16'sd1;
  logic               integrate = 1'b1;
  logic               hold_mode = 1'b1;
  logic signed [16:0] dac_data;
  logic               dac_valid;
  logic               sat_flag;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pi_feedback_controller dut (
    .clk       (clk),
    .resetn    (resetn),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .setpoint  (setpoint),
    .kp        (kp),
    .ki        (ki),
    .integrate (integrate),
    .hold_mode (hold_mode),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .sat_flag  (sat_flag)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int v);
    @(posedge clk); #1;
    adc_data  = 19'(v);
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  // Called right after send(): negedge j follows edge N+j, result due at j=4.
  task automatic expect_dac(input string tag, input int exp, input int exp_sat);
    int lat;
    lat = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (dac_valid) begin
        lat = j;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 4);
    if (lat != 0) begin
      chk(tag, dac_data, exp);
      chk({tag, "_sat"}, sat_flag, exp_sat);
      @(negedge clk);
      chk({tag, "_strobe"}, dac_valid, 0);
      chk({tag, "_hold"}, dac_data, exp);
    end
  endtask

  task automatic clear_acc();
    @(posedge clk); #1;
    integrate = 1'b0;
    hold_mode = 1'b0;
    @(posedge clk); #1;
    integrate = 1'b1;
    hold_mode = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_dac", dac_data, 0);
    chk("rst_vld", dac_valid, 0);
    chk("rst_sat", sat_flag, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    // integrate: err 100 then 500
    send(1100); expect_dac("t1a", 100, 0);
    repeat (10) @(posedge clk);
    send(1500); expect_dac("t1b", 600, 0);

    // hold freezes acc at 600, clear drops it to 0
    @(posedge clk); #1;
    integrate = 1'b0;
    hold_mode = 1'b1;
    send(10000); expect_dac("t3_hold", 600, 0);
    #1 hold_mode = 1'b0;
    repeat (2) @(posedge clk);
    send(1100); expect_dac("t3_clr", 0, 0);

    // anti-windup at +65535
    integrate = 1'b1;
    hold_mode = 1'b1;
    clear_acc();
    ki = 16'sd100;
    for (int k = 0; k < 4; k++) begin
      send(10000); expect_dac("t2_wind", 65535, 1);
    end
    ki = 16'sd1;
    send(900); expect_dac("t2_unwind", 65435, 0);

    // proportional only, then negative DAC saturation
    clear_acc();
    kp = 16'sd2;
    ki = 16'sd0;
    send(1500); expect_dac("t4_p", 1000, 0);
    send(-200000); expect_dac("t4_neg", -65536, 1);

    // back-to-back samples
    kp = 16'sd0;
    ki = 16'sd1;
    clear_acc();
    @(posedge clk); #1; adc_data = 19'sd1100; adc_valid = 1'b1;
    @(posedge clk); #1; adc_data = 19'sd1200;
    @(posedge clk); #1; adc_data = 19'sd1300;
    @(posedge clk); #1; adc_valid = 1'b0;
    @(negedge clk); chk("t5_pre", dac_valid, 0);
    @(negedge clk); chk("t5_v0", dac_valid, 1); chk("t5_d0", dac_data, 100);
    @(negedge clk); chk("t5_v1", dac_valid, 1); chk("t5_d1", dac_data, 300);
    @(negedge clk); chk("t5_v2", dac_valid, 1); chk("t5_d2", dac_data, 600);
    @(negedge clk); chk("t5_end", dac_valid, 0);

    // reset with a sample at S2 (acc and dac currently 600)
    begin
      int seen;
      seen = 0;
      @(posedge clk); #1; adc_data = 19'sd1100; adc_valid = 1'b1;
      @(posedge clk); #1; adc_valid = 1'b0;
      @(posedge clk); #1; resetn = 1'b0;
      #1 chk("t6_async_dac", dac_data, 0);
      @(posedge clk); #1; resetn = 1'b1;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        if (dac_valid) seen++;
      end
      chk("t6_novld", seen, 0);
      chk("t6_dac", dac_data, 0);
      chk("t6_sat", sat_flag, 0);
    end
    send(1100); expect_dac("t6_next", 100, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
